// File: rtl/pe3x3_row_ctrl_pkg.sv
// Shared constants and types for the pe3x3 row sequencer and its accumulator bank.
// Word format is Q24.8 two's complement; latencies describe the row buffer and PE pipeline.
package pe3x3_row_ctrl_pkg;

    localparam int Q_IW        = 24;
    localparam int Q_FW        = 8;
    localparam int Q_DW        = Q_IW + Q_FW;
    localparam int OUT_NUM_DEF = 9;
    localparam int ROW_AW_DEF  = 8;

    localparam logic [1:0] KY_LAST = 2'd2;
    localparam int         BUF_LAT = 1;
    localparam int         PE_LAT  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/pe_row_acc.sv
// Bank of OUT_NUM signed accumulators; load overwrites, add sums with two's-complement wrap.
// Used to fold the three kernel-row partial sums into one output row.
module pe_row_acc
    import pe3x3_row_ctrl_pkg::*;
#(
    parameter int DW      = Q_DW,
    parameter int OUT_NUM = OUT_NUM_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  add_i,
    input  logic [OUT_NUM*DW-1:0] data_i,
    output logic [OUT_NUM*DW-1:0] acc_o
);

    logic signed [DW-1:0] acc_q [OUT_NUM];
    logic signed [DW-1:0] acc_d [OUT_NUM];

    always_comb begin
        for (int k = 0; k < OUT_NUM; k++) begin
            acc_d[k] = acc_q[k];
            if (load_i) begin
                acc_d[k] = $signed(data_i[k*DW +: DW]);
            end else if (add_i) begin
                acc_d[k] = acc_q[k] + $signed(data_i[k*DW +: DW]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < OUT_NUM; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            acc_q <= acc_d;
        end
    end

    for (genvar k = 0; k < OUT_NUM; k++) begin : g_out
        assign acc_o[k*DW +: DW] = acc_q[k];
    end

endmodule

// File: rtl/pe3x3_row_ctrl.sv
// Row sequencer for one pe3x3 PE: issues three row-buffer reads per output row, steps ky,
// folds the tagged PE results into one row and hands it downstream over valid/ready.
module pe3x3_row_ctrl
    import pe3x3_row_ctrl_pkg::*;
#(
    parameter int DW      = Q_DW,
    parameter int OUT_NUM = OUT_NUM_DEF,
    parameter int ROW_AW  = ROW_AW_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ROW_AW-1:0]     num_rows_i,
    input  logic                  cfg_united_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fbuf_rd_en_o,
    output logic [ROW_AW-1:0]     fbuf_rd_addr_o,
    output logic [1:0]            wht_sel_o,
    output logic                  pe_config_o,
    input  logic [OUT_NUM*DW-1:0] pe_res_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [OUT_NUM*DW-1:0] out_data_o,
    output logic [ROW_AW-1:0]     out_row_o
);

    // Tag travels alongside the read: one stage for the buffer, one for the registered PE.
    localparam int TAG_DEPTH = BUF_LAT + PE_LAT;

    state_e                       state_q, state_d;
    logic [ROW_AW-1:0]            out_row_q, out_row_d;
    logic [ROW_AW-1:0]            num_rows_q, num_rows_d;
    logic [1:0]                   ky_q, ky_d;
    logic                         cfg_q, cfg_d;
    logic                         done_q, done_d;
    logic [TAG_DEPTH-1:0]         tag_vld_q, tag_vld_d;
    logic [TAG_DEPTH-1:0][1:0]    tag_ky_q, tag_ky_d;

    logic       issue;
    logic       tag_last_vld;
    logic [1:0] tag_last_ky;
    logic       acc_load;
    logic       acc_add;
    logic       row_last;

    assign issue        = (state_q == ST_ISSUE);
    assign tag_last_vld = tag_vld_q[TAG_DEPTH-1];
    assign tag_last_ky  = tag_ky_q[TAG_DEPTH-1];
    assign acc_load     = tag_last_vld && (tag_last_ky == 2'd0);
    assign acc_add      = tag_last_vld && (tag_last_ky != 2'd0);
    assign row_last     = ((out_row_q + ROW_AW'(1)) == num_rows_q);

    always_comb begin
        tag_vld_d = {tag_vld_q[TAG_DEPTH-2:0], issue};
        tag_ky_d  = {tag_ky_q[TAG_DEPTH-2:0], (issue ? ky_q : 2'd0)};
    end

    always_comb begin
        state_d    = state_q;
        out_row_d  = out_row_q;
        num_rows_d = num_rows_q;
        ky_d       = ky_q;
        cfg_d      = cfg_q;
        done_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    cfg_d      = cfg_united_i;
                    num_rows_d = num_rows_i;
                    out_row_d  = '0;
                    ky_d       = 2'd0;
                    state_d    = (num_rows_i == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ky_q == KY_LAST) begin
                    ky_d    = 2'd0;
                    state_d = ST_WAIT;
                end else begin
                    ky_d = ky_q + 2'd1;
                end
            end
            ST_WAIT: begin
                if (tag_last_vld && (tag_last_ky == KY_LAST)) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready_i) begin
                    if (row_last) begin
                        state_d = ST_DONE;
                    end else begin
                        out_row_d = out_row_q + ROW_AW'(1);
                        ky_d      = 2'd0;
                        state_d   = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            out_row_q  <= '0;
            num_rows_q <= '0;
            ky_q       <= 2'd0;
            cfg_q      <= 1'b0;
            done_q     <= 1'b0;
            tag_vld_q  <= '0;
            tag_ky_q   <= '0;
        end else begin
            state_q    <= state_d;
            out_row_q  <= out_row_d;
            num_rows_q <= num_rows_d;
            ky_q       <= ky_d;
            cfg_q      <= cfg_d;
            done_q     <= done_d;
            tag_vld_q  <= tag_vld_d;
            tag_ky_q   <= tag_ky_d;
        end
    end

    pe_row_acc #(
        .DW      (DW),
        .OUT_NUM (OUT_NUM)
    ) u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (acc_load),
        .add_i  (acc_add),
        .data_i (pe_res_i),
        .acc_o  (out_data_o)
    );

    // wht_sel follows the buffer stage so it meets the fetched row at the PE input.
    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = done_q;
    assign fbuf_rd_en_o   = issue;
    assign fbuf_rd_addr_o = issue ? (out_row_q + ROW_AW'(ky_q)) : '0;
    assign wht_sel_o      = tag_ky_q[BUF_LAT-1];
    assign pe_config_o    = cfg_q;
    assign out_valid_o    = (state_q == ST_OUT);
    assign out_row_o      = out_row_q;

endmodule

// File: tb/tb_pe3x3_row_ctrl.sv
// Directed bench for pe3x3_row_ctrl with a behavioural row buffer + PE and a row scoreboard.
module tb_pe3x3_row_ctrl;

    localparam int DW      = 32;
    localparam int OUT_NUM = 9;
    localparam int ROW_AW  = 8;
    localparam int VW      = DW * OUT_NUM;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start_i = 1'b0;
    logic [ROW_AW-1:0] num_rows_i = '0;
    logic              cfg_united_i = 1'b0;
    logic              out_ready_i = 1'b1;
    logic              busy_o, done_o, fbuf_rd_en_o, pe_config_o, out_valid_o;
    logic [ROW_AW-1:0] fbuf_rd_addr_o, out_row_o;
    logic [1:0]        wht_sel_o;
    logic [VW-1:0]     pe_res_i, out_data_o;

    pe3x3_row_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .num_rows_i     (num_rows_i),
        .cfg_united_i   (cfg_united_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .fbuf_rd_en_o   (fbuf_rd_en_o),
        .fbuf_rd_addr_o (fbuf_rd_addr_o),
        .wht_sel_o      (wht_sel_o),
        .pe_config_o    (pe_config_o),
        .pe_res_i       (pe_res_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .out_row_o      (out_row_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int mode   = 0;

    typedef struct {
        logic [ROW_AW-1:0] row;
        logic [VW-1:0]     data;
    } beat_t;

    beat_t             sb[$];
    logic [ROW_AW-1:0] rd_log[$];
    int                beat_cyc[$];
    int                done_cyc[$];

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // PE word for a given input row and kernel row; several modes exercise different data.
    function automatic logic [DW-1:0] pe_word(input int m, input logic [ROW_AW-1:0] a,
                                              input logic [1:0] ky, input int k);
        logic [DW-1:0] kyw;
        kyw = {30'd0, ky};
        case (m)
            0:       return (kyw + 32'd1) << 8;
            1:       return (({24'd0, a} << 12) + ((kyw + 32'd1) << 8) + 32'(k))
                            ^ ((ky == 2'd1) ? 32'h8000_0000 : 32'h0);
            2:       return 32'hFFFF_FF00;
            default: return (ky == 2'd0) ? 32'h7FFF_FFFF : ((ky == 2'd1) ? 32'd1 : 32'd0);
        endcase
    endfunction

    function automatic logic [VW-1:0] pe_vec(input int m, input logic [ROW_AW-1:0] a,
                                             input logic [1:0] ky);
        logic [VW-1:0] v;
        for (int k = 0; k < OUT_NUM; k++) v[k*DW +: DW] = pe_word(m, a, ky, k);
        return v;
    endfunction

    function automatic logic [VW-1:0] exp_row(input int m, input logic [ROW_AW-1:0] r);
        logic [VW-1:0]     v;
        logic [DW-1:0]     s;
        logic [ROW_AW-1:0] a;
        for (int k = 0; k < OUT_NUM; k++) begin
            s = '0;
            for (int j = 0; j < 3; j++) begin
                a = r + ROW_AW'(j);
                s = s + pe_word(m, a, 2'(j), k);
            end
            v[k*DW +: DW] = s;
        end
        return v;
    endfunction

    // Row buffer (1 cycle) followed by a registered PE that captures wht_sel with the row.
    logic              s1_v = 1'b0, s2_v = 1'b0;
    logic [ROW_AW-1:0] s1_a = '0, s2_a = '0;
    logic [1:0]        s2_ky = '0;
    always @(posedge clk) begin
        s1_v  <= fbuf_rd_en_o;
        s1_a  <= fbuf_rd_addr_o;
        s2_v  <= s1_v;
        s2_a  <= s1_a;
        s2_ky <= wht_sel_o;
    end
    always_comb pe_res_i = s2_v ? pe_vec(mode, s2_a, s2_ky) : {OUT_NUM{32'hDEAD_BEEF}};

    always @(negedge clk) begin : monitor
        beat_t b;
        if (rst_n) begin
            if (fbuf_rd_en_o) rd_log.push_back(fbuf_rd_addr_o);
            if (done_o) done_cyc.push_back(cyc);
            if (out_valid_o && out_ready_i) begin
                beat_cyc.push_back(cyc);
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_unexpected_beat observed=row %0d expected=no beat", out_row_o);
                end
                if (sb.size() != 0) begin
                    b = sb.pop_front();
                    chk("beat_row", VW'(out_row_o), VW'(b.row));
                    chk("beat_data", out_data_o, b.data);
                end
            end
        end
    end

    task automatic clear_logs();
        rd_log.delete();
        beat_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic start_job(input logic [ROW_AW-1:0] n, input logic cfg, input int m);
        mode = m;
        for (int r = 0; r < int'(n); r++) sb.push_back('{row: ROW_AW'(r), data: exp_row(m, ROW_AW'(r))});
        num_rows_i   = n;
        cfg_united_i = cfg;
        start_i      = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int lim, input string tag);
        int n = 0;
        @(negedge clk);
        while (!done_o && n < lim) begin @(negedge clk); n++; end
        chk(tag, VW'(done_o), VW'(1'b1));
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input int lim, input string tag);
        int n = 0;
        @(negedge clk);
        while (!out_valid_o && n < lim) begin @(negedge clk); n++; end
        chk(tag, VW'(out_valid_o), VW'(1'b1));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  VW'(busy_o), '0);
        chk({tag, "_done"},  VW'(done_o), '0);
        chk({tag, "_rd_en"}, VW'(fbuf_rd_en_o), '0);
        chk({tag, "_addr"},  VW'(fbuf_rd_addr_o), '0);
        chk({tag, "_wht"},   VW'(wht_sel_o), '0);
        chk({tag, "_cfg"},   VW'(pe_config_o), '0);
        chk({tag, "_valid"}, VW'(out_valid_o), '0);
        chk({tag, "_data"},  out_data_o, '0);
        chk({tag, "_row"},   VW'(out_row_o), '0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin : main
        int                n;
        logic [VW-1:0]     hold;
        logic [ROW_AW-1:0] hrow;

        // Reset state
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single row: 0x100+0x200+0x300 per word, cycle-exact timing
        clear_logs();
        start_job(8'd1, 1'b0, 0);
        for (int rel = 1; rel <= 9; rel++) begin
            @(negedge clk);
            chk("t1_rd_en", VW'(fbuf_rd_en_o), VW'(rel >= 1 && rel <= 3));
            if (rel <= 3) chk("t1_rd_addr", VW'(fbuf_rd_addr_o), VW'(rel - 1));
            if (rel >= 2 && rel <= 4) chk("t1_wht_sel", VW'(wht_sel_o), VW'(rel - 2));
            chk("t1_valid", VW'(out_valid_o), VW'(rel == 6));
            if (rel == 6) begin
                chk("t1_data", out_data_o, {OUT_NUM{32'h0000_0600}});
                chk("t1_row", VW'(out_row_o), '0);
            end
            chk("t1_done", VW'(done_o), VW'(rel == 8));
        end
        @(posedge clk); #1;

        // Four rows back to back
        clear_logs();
        start_job(8'd4, 1'b0, 1);
        wait_done(60, "t2_done_timeout");
        chk("t2_rd_count", VW'(rd_log.size()), VW'(12));
        for (int i = 0; i < 12 && i < rd_log.size(); i++)
            chk("t2_rd_addr", VW'(rd_log[i]), VW'(i / 3 + i % 3));
        chk("t2_beat_count", VW'(beat_cyc.size()), VW'(4));
        for (int i = 1; i < beat_cyc.size(); i++)
            chk("t2_beat_gap", VW'(beat_cyc[i] - beat_cyc[i-1]), VW'(6));
        chk("t2_done_count", VW'(done_cyc.size()), VW'(1));
        if (done_cyc.size() == 1 && beat_cyc.size() == 4)
            chk("t2_done_after_last", VW'(done_cyc[0] - beat_cyc[3]), VW'(2));

        // Backpressure during OUT
        clear_logs();
        out_ready_i = 1'b0;
        start_job(8'd2, 1'b0, 1);
        wait_valid(20, "t3_valid_timeout");
        hold = out_data_o;
        hrow = out_row_o;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", VW'(out_valid_o), VW'(1'b1));
            chk("t3_hold_data", out_data_o, hold);
            chk("t3_hold_row", VW'(out_row_o), VW'(hrow));
            chk("t3_no_read", VW'(fbuf_rd_en_o), '0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t3_valid_drop", VW'(out_valid_o), '0);
        chk("t3_next_issue", VW'(fbuf_rd_en_o), VW'(1'b1));
        chk("t3_next_addr", VW'(fbuf_rd_addr_o), VW'(1));
        wait_done(40, "t3_done_timeout");
        chk("t3_beat_count", VW'(beat_cyc.size()), VW'(2));
        chk("t3_rd_count", VW'(rd_log.size()), VW'(6));

        // Signed wrap
        start_job(8'd1, 1'b0, 2);
        wait_valid(20, "t4a_valid_timeout");
        chk("t4a_neg_sum", out_data_o, {OUT_NUM{32'hFFFF_FD00}});
        wait_done(20, "t4a_done_timeout");
        start_job(8'd1, 1'b0, 3);
        wait_valid(20, "t4b_valid_timeout");
        chk("t4b_pos_wrap", out_data_o, {OUT_NUM{32'h8000_0000}});
        wait_done(20, "t4b_done_timeout");

        // Zero-row start, united mode, start ignored while busy
        clear_logs();
        start_job(8'd0, 1'b1, 0);
        for (int rel = 1; rel <= 3; rel++) begin
            @(negedge clk);
            chk("t5_zero_rd_en", VW'(fbuf_rd_en_o), '0);
            chk("t5_zero_busy", VW'(busy_o), VW'(rel == 1));
            chk("t5_zero_done", VW'(done_o), VW'(rel == 2));
            chk("t5_zero_cfg", VW'(pe_config_o), VW'(1'b1));
        end
        chk("t5_zero_no_reads", VW'(rd_log.size()), '0);
        @(posedge clk); #1;
        clear_logs();
        start_job(8'd2, 1'b1, 0);
        start_i      = 1'b1;
        num_rows_i   = 8'd5;
        cfg_united_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t5_cfg_hold", VW'(pe_config_o), VW'(1'b1));
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        n = 0;
        @(negedge clk);
        while (busy_o && n < 40) begin
            chk("t5_cfg_job", VW'(pe_config_o), VW'(1'b1));
            @(negedge clk);
            n++;
        end
        chk("t5_busy_timeout", VW'(busy_o), '0);
        chk("t5_done_end", VW'(done_o), VW'(1'b1));
        chk("t5_beat_count", VW'(beat_cyc.size()), VW'(2));
        chk("t5_rd_count", VW'(rd_log.size()), VW'(6));
        chk("t5_cfg_after", VW'(pe_config_o), VW'(1'b1));
        @(posedge clk); #1;

        // Asynchronous reset during WAIT
        start_job(8'd1, 1'b0, 0);
        repeat (4) @(negedge clk);
        chk("t6_pre_busy", VW'(busy_o), VW'(1'b1));
        rst_n = 1'b0;
        #1 chk_all_zero("t6_rst");
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        repeat (10) begin
            @(negedge clk);
            chk("t6_idle_valid", VW'(out_valid_o), '0);
            chk("t6_idle_busy", VW'(busy_o), '0);
            chk("t6_idle_rd", VW'(fbuf_rd_en_o), '0);
        end
        @(posedge clk); #1;
        start_job(8'd1, 1'b0, 1);
        wait_done(20, "t6_restart_done");
        chk("t6_restart_beats", VW'(beat_cyc.size()), VW'(1));
        chk("sb_drained", VW'(sb.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
